// File: rtl/bbc_csr_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bbc_csr_boot_sequencer
// Purpose  : CSR bus master that walks an external combinational table of
//            CSR reads/writes after reset (or on start), with a per-entry
//            ack/read-data timeout and status mirrored on an LED bank.
// Revision : 1.0 - initial release
// ============================================================================
module bbc_csr_boot_sequencer #(
    parameter int DEPTH      = 16,
    parameter int IDX_W      = 4,
    parameter int TIMEOUT    = 1023,
    parameter int AUTO_START = 1,
    parameter int LED_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [IDX_W-1:0]  table_index,
    input  logic              table_entry__valid,
    input  logic              table_entry__read_not_write,
    input  logic [15:0]       table_entry__select,
    input  logic [15:0]       table_entry__address,
    input  logic [31:0]       table_entry__data,
    output logic              csr_request__valid,
    output logic              csr_request__read_not_write,
    output logic [15:0]       csr_request__select,
    output logic [15:0]       csr_request__address,
    output logic [31:0]       csr_request__data,
    input  logic              csr_response__ack,
    input  logic              csr_response__read_data_valid,
    input  logic [31:0]       csr_response__read_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  error_index,
    output logic [31:0]       last_read_data,
    output logic [LED_W-1:0]  leds
);

    // Counter only has to reach TIMEOUT-1: the cycle holding that value is the last one allowed.
    localparam int               CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_REQUEST   = 3'd2,
        S_WAIT_DATA = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_armed;
    logic [IDX_W-1:0]   r_idx,   w_idx_nx;
    logic               r_vld,   w_vld_nx;
    logic               r_rnw,   w_rnw_nx;
    logic [15:0]        r_sel,   w_sel_nx;
    logic [15:0]        r_addr,  w_addr_nx;
    logic [31:0]        r_data,  w_data_nx;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nx;
    logic               r_busy,  w_busy_nx;
    logic               r_done,  w_done_nx;
    logic               r_err,   w_err_nx;
    logic [IDX_W-1:0]   r_eidx,  w_eidx_nx;
    logic [31:0]        r_lrd,   w_lrd_nx;
    logic               w_complete;
    logic               w_timeout;
    logic               w_start_seq;

    // State register; async reset also kills any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_vld_nx    = r_vld;
        w_rnw_nx    = r_rnw;
        w_sel_nx    = r_sel;
        w_addr_nx   = r_addr;
        w_data_nx   = r_data;
        w_cnt_nx    = r_cnt;
        w_done_nx   = r_done;
        w_err_nx    = r_err;
        w_eidx_nx   = r_eidx;
        w_lrd_nx    = r_lrd;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        w_start_seq = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start || ((AUTO_START != 0) && !r_armed)) begin
                    w_start_seq = 1'b1;
                end
            end
            S_FETCH: begin
                if (!table_entry__valid) begin
                    w_state_nx = S_DONE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_vld_nx   = 1'b1;
                    w_rnw_nx   = table_entry__read_not_write;
                    w_sel_nx   = table_entry__select;
                    w_addr_nx  = table_entry__address;
                    w_data_nx  = table_entry__data;
                    w_cnt_nx   = '0;
                    w_state_nx = S_REQUEST;
                end
            end
            S_REQUEST: begin
                w_cnt_nx = r_cnt + CNT_W'(1);
                if (csr_response__ack) begin
                    w_vld_nx = 1'b0;
                    if (!r_rnw) begin
                        w_complete = 1'b1;
                    end else if (csr_response__read_data_valid) begin
                        w_lrd_nx   = csr_response__read_data;
                        w_complete = 1'b1;
                    end else begin
                        w_state_nx = S_WAIT_DATA;
                    end
                end
                w_timeout = !w_complete && (r_cnt == C_CNT_LAST);
            end
            S_WAIT_DATA: begin
                w_cnt_nx = r_cnt + CNT_W'(1);
                if (csr_response__read_data_valid) begin
                    w_lrd_nx   = csr_response__read_data;
                    w_complete = 1'b1;
                end
                w_timeout = !w_complete && (r_cnt == C_CNT_LAST);
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    w_start_seq = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Completion wins over a timeout landing on the same cycle.
        if (w_complete) begin
            if (r_idx == C_IDX_LAST) begin
                w_state_nx = S_DONE;
                w_done_nx  = 1'b1;
            end else begin
                w_idx_nx   = r_idx + IDX_W'(1);
                w_state_nx = S_FETCH;
            end
        end else if (w_timeout) begin
            w_state_nx = S_ERROR;
            w_vld_nx   = 1'b0;
            w_err_nx   = 1'b1;
            w_eidx_nx  = r_idx;
        end

        if (w_start_seq) begin
            w_state_nx = S_FETCH;
            w_idx_nx   = '0;
            w_done_nx  = 1'b0;
            w_err_nx   = 1'b0;
            w_eidx_nx  = '0;
        end

        w_busy_nx = (w_state_nx == S_FETCH) || (w_state_nx == S_REQUEST) ||
                    (w_state_nx == S_WAIT_DATA);
    end

    // Registered request fields, status and captured read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_rnw   <= 1'b0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_eidx  <= '0;
            r_lrd   <= '0;
        end else begin
            r_armed <= 1'b1;
            r_idx   <= w_idx_nx;
            r_vld   <= w_vld_nx;
            r_rnw   <= w_rnw_nx;
            r_sel   <= w_sel_nx;
            r_addr  <= w_addr_nx;
            r_data  <= w_data_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_eidx  <= w_eidx_nx;
            r_lrd   <= w_lrd_nx;
        end
    end

    assign table_index                 = r_idx;
    assign csr_request__valid          = r_vld;
    assign csr_request__read_not_write = r_rnw;
    assign csr_request__select         = r_sel;
    assign csr_request__address        = r_addr;
    assign csr_request__data           = r_data;
    assign busy                        = r_busy;
    assign done                        = r_done;
    assign error                       = r_err;
    assign error_index                 = r_eidx;
    assign last_read_data              = r_lrd;
    assign leds                        = {r_err, r_done, r_lrd[LED_W-3:0]};

endmodule
`default_nettype wire
